nco_sincos_32x16: RTL and testbench
===================================

Name: nco_sincos_32x16

Overview:
- Numerically controlled oscillator that produces quadrature sine/cosine samples.
- Built from a 32-bit phase accumulator feeding a pipelined 16-iteration CORDIC rotator.
- Used as the local-oscillator / reference-tone source in the notch-filter datapath.
- Typical use: 24 MHz clk with phi_inc_i = 0x001B4E82 (1789570), giving a 10 kHz tone of 2400 samples per period.

Parameters:
- ACC_W, 32, phase accumulator and phase-increment width.
- OUT_W, 16, output sample width (two's complement).
- PH_W, 18, accumulator MSBs passed to the CORDIC (rest truncated, no dither).
- LAT, 18, clken-qualified cycles from accumulator sample to output.

Ports:
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, synchronous active-low reset.
- clken, in, 1, clock enable; 0 freezes all state.
- phi_inc_i, in, 32, unsigned phase increment per sample.
- fsin_o, out, 16, signed sine sample.
- fcos_o, out, 16, signed cosine sample.
- out_valid, out, 1, high when fsin_o/fcos_o hold a valid sample.

Behaviour:
- Reset: synchronous, active-low; clock clk. Evaluated on posedge clk only when reset_n=0, regardless of clken.
  - Clears accumulator, all pipeline registers, valid counter.
  - Forces fsin_o=0, fcos_o=0, out_valid=0.
  - Reset asserted mid-operation discards the in-flight pipeline, and the next out_valid comes only after LAT new enabled cycles.
- Accumulator (each posedge with reset_n=1, clken=1):
  - acc <= acc + phi_inc_i, modulo 2^32 (wraps silently).
  - The pre-add value of acc enters the pipeline, so the first sample after reset has phase 0.
  - phi_inc_i is sampled every enabled cycle; a change affects the phase of the next sample only, and phase stays continuous.
- Phase mapping:
  - p = acc[31:14]; the top 2 bits select the quadrant.
  - The remaining bits are rotated by CORDIC within [-pi/4, pi/4) relative to the quadrant start, or equivalently folded to the first quadrant.
  - Signs and sin/cos swap are restored after the last stage.
- CORDIC:
  - 16 registered iterations, internal datapath 20 bits signed.
  - Initial x = round(32767/1.64676) = 19898, y = 0.
  - Arctangent constants are held in an internal 16-entry table scaled to the 18-bit phase unit.
- Output register:
  - Round to 16 bits and saturate to [-32767, +32767]; -32768 is never produced.
  - Accuracy: |fsin_o - round(32767*sin(2*pi*acc/2^32))| <= 3 LSB, same for cos.
- Latency: a sample taken at enabled cycle n appears at the outputs after enabled cycle n+LAT-1 (LAT = 18).
- out_valid:
  - A saturating counter of enabled cycles since reset; out_valid=1 once it reaches LAT and stays 1 until the next reset.
  - Outputs are 0 while out_valid=0.
- clken=0: accumulator, pipeline, counter and outputs all hold their values, and out_valid holds its level. Resuming continues with no sample lost or duplicated.
- phi_inc_i = 0: constant output (sin=0, cos=32767 after reset).
- phi_inc_i = 0x80000000: output alternates between phase 0 and phase pi (sin≈0, cos ±32767).

Test Plan:
- Reset then clken=1, phi_inc_i=0x001B4E82 -> out_valid rises exactly 18 cycles after reset_n rises. First valid sample sin=0±3, cos=32767±3. Sample k=600 gives sin≈32767, cos≈0±3. Sample k=2400 returns to sin≈0, cos≈32767.
- Same run over 24000 valid samples -> every sample within ±3 LSB of the ideal; sin^2+cos^2 within 0.05% of 32767^2; period exactly 2400 samples with no phase drift beyond truncation.
- phi_inc_i=0x40000000 -> repeating (sin,cos) sequence (0,32767), (32767,0), (0,-32767), (-32767,0), each ±3.
- Toggle clken low for 5 cycles mid-stream -> outputs and out_valid frozen; sequence resumes with no skipped or repeated samples relative to an uninterrupted reference.
- Change phi_inc_i from 0x001B4E82 to 0x0036 9D04 mid-stream -> the sample following the change advances by the new increment with no phase jump; the frequency doubles.
- Assert reset_n=0 for 1 cycle mid-stream -> next edge outputs 0 and out_valid=0; restart behaves as in the first scenario.

Source files
------------

// File: rtl/nco_sincos_32x16.sv
// ---------------------------------------------------------------------------
// nco_sincos_32x16
//
// Numerically controlled oscillator producing quadrature sine/cosine samples.
// A 32-bit phase accumulator feeds a 16-iteration pipelined CORDIC rotator.
// Each enabled cycle the pre-add accumulator value enters the pipeline and the
// matching sample appears LAT enabled cycles later, rounded and saturated to
// a symmetric 16-bit range.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset (acts regardless of clken)
//   clken      clock enable; 0 freezes every register
//   phi_inc_i  unsigned phase increment per sample (full turn = 2^32)
//   fsin_o     signed sine sample, 0 while out_valid is low
//   fcos_o     signed cosine sample, 0 while out_valid is low
//   out_valid  high once LAT enabled cycles have elapsed since reset
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module nco_sincos_32x16 #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 16,
   parameter int PH_W  = 18,
   parameter int LAT   = 18
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic [ACC_W-1:0]        phi_inc_i,
   output logic signed [OUT_W-1:0] fsin_o,
   output logic signed [OUT_W-1:0] fcos_o,
   output logic                    out_valid
);

   localparam int NIT = 16;                 // CORDIC iterations
   localparam int DW  = 20;                 // internal x/y/z width
   localparam int GB  = 3;                  // guard bits below the output LSB on x/y
   localparam int ZF  = 2;                  // fractional bits below the phase LSB on z
   localparam int CW  = $clog2(LAT + 1);

   // 19898 = round(32767 / CORDIC gain), pre-scaled by the guard bits
   localparam logic signed [DW-1:0] X_INIT = DW'(19898 * (2 ** GB));
   localparam logic signed [DW:0]   SAT_HI = (DW+1)'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [DW:0]   SAT_LO = -SAT_HI;

   // atan(2^-i) in 18-bit phase LSBs with ZF fractional bits (2^20 per turn)
   function automatic logic signed [DW-1:0] atan_lut(input int i);
      logic signed [DW-1:0] a;
      case (i)
         0:       a = 20'sd131072;
         1:       a = 20'sd77376;
         2:       a = 20'sd40884;
         3:       a = 20'sd20753;
         4:       a = 20'sd10417;
         5:       a = 20'sd5213;
         6:       a = 20'sd2607;
         7:       a = 20'sd1304;
         8:       a = 20'sd652;
         9:       a = 20'sd326;
         10:      a = 20'sd163;
         11:      a = 20'sd81;
         12:      a = 20'sd41;
         13:      a = 20'sd20;
         14:      a = 20'sd10;
         15:      a = 20'sd5;
         default: a = 20'sd0;
      endcase
      return a;
   endfunction

   // Drop the guard bits with round-half-up, then clamp to +-(2^(OUT_W-1)-1)
   function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [DW-1:0] v);
      logic signed [DW:0]      t;
      logic signed [OUT_W-1:0] r;
      t = $signed({v[DW-1], v}) + $signed((DW+1)'(2 ** (GB - 1)));
      t = t >>> GB;
      if (t > SAT_HI) begin
         r = SAT_HI[OUT_W-1:0];
      end else if (t < SAT_LO) begin
         r = SAT_LO[OUT_W-1:0];
      end else begin
         r = t[OUT_W-1:0];
      end
      return r;
   endfunction

   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [PH_W-1:0]         ph;

   logic signed [DW-1:0]    x_q    [0:NIT];
   logic signed [DW-1:0]    x_d    [0:NIT];
   logic signed [DW-1:0]    y_q    [0:NIT];
   logic signed [DW-1:0]    y_d    [0:NIT];
   logic signed [DW-1:0]    z_q    [0:NIT];
   logic signed [DW-1:0]    z_d    [0:NIT];
   logic [1:0]              quad_q [0:NIT];
   logic [1:0]              quad_d [0:NIT];

   logic signed [OUT_W-1:0] xo, yo;
   logic signed [OUT_W-1:0] fsin_q, fsin_d;
   logic signed [OUT_W-1:0] fcos_q, fcos_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    vld_q, vld_d;

   assign ph = acc_q[ACC_W-1 -: PH_W];

   always_comb begin
      // accumulator: wraps modulo 2^ACC_W
      acc_d = acc_q + phi_inc_i;

      // ---- stage p0: quadrant select and residual angle ----
      // Round the phase to the nearest quadrant start so the residual lies in
      // [-pi/4, pi/4); the sign-extended low bits are exactly that residual.
      quad_d[0] = ph[PH_W-1 -: 2] + {1'b0, ph[PH_W-3]};
      z_d[0]    = $signed({{(DW - PH_W + 2 - ZF){ph[PH_W-3]}}, ph[PH_W-3:0], {ZF{1'b0}}});
      x_d[0]    = X_INIT;
      y_d[0]    = '0;

      // ---- stages p1..p16: one CORDIC micro-rotation each ----
      for (int s = 0; s < NIT; s++) begin
         if (z_q[s][DW-1]) begin
            x_d[s+1] = x_q[s] + (y_q[s] >>> s);
            y_d[s+1] = y_q[s] - (x_q[s] >>> s);
            z_d[s+1] = z_q[s] + atan_lut(s);
         end else begin
            x_d[s+1] = x_q[s] - (y_q[s] >>> s);
            y_d[s+1] = y_q[s] + (x_q[s] >>> s);
            z_d[s+1] = z_q[s] - atan_lut(s);
         end
         quad_d[s+1] = quad_q[s];
      end

      // ---- output stage: round, saturate, restore quadrant ----
      xo = rnd_sat(x_q[NIT]);
      yo = rnd_sat(y_q[NIT]);

      cnt_d = (cnt_q == CW'(LAT)) ? cnt_q : cnt_q + 1'b1;
      vld_d = (cnt_d == CW'(LAT));

      fsin_d = '0;
      fcos_d = '0;
      if (vld_d) begin
         case (quad_q[NIT])
            2'd0: begin fsin_d =  yo; fcos_d =  xo; end
            2'd1: begin fsin_d =  xo; fcos_d = -yo; end
            2'd2: begin fsin_d = -yo; fcos_d = -xo; end
            default: begin fsin_d = -xo; fcos_d =  yo; end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q  <= '0;
         for (int s = 0; s <= NIT; s++) begin
            x_q[s]    <= '0;
            y_q[s]    <= '0;
            z_q[s]    <= '0;
            quad_q[s] <= '0;
         end
         fsin_q <= '0;
         fcos_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else if (clken) begin
         acc_q  <= acc_d;
         for (int s = 0; s <= NIT; s++) begin
            x_q[s]    <= x_d[s];
            y_q[s]    <= y_d[s];
            z_q[s]    <= z_d[s];
            quad_q[s] <= quad_d[s];
         end
         fsin_q <= fsin_d;
         fcos_q <= fcos_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   assign fsin_o    = fsin_q;
   assign fcos_o    = fcos_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_nco_sincos_32x16.sv
// ---------------------------------------------------------------------------
// tb_nco_sincos_32x16
//
// Directed bench for nco_sincos_32x16. Expected samples are chosen at phases
// that land exactly on multiples of 45 degrees after truncation, so the ideal
// values (0, +-23170, +-32767) are known by hand; CORDIC results are accepted
// within +-3 LSB, control outputs are compared exactly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nco_sincos_32x16;

   localparam int LAT = 18;
   localparam int TOL = 3;
   localparam logic [31:0] PHI1 = 32'h001B4E82;
   localparam logic [31:0] PHI2 = 32'h00369D04;

   logic               clk;
   logic               reset_n;
   logic               clken;
   logic [31:0]        phi_inc_i;
   logic signed [15:0] fsin_o;
   logic signed [15:0] fcos_o;
   logic               out_valid;

   int total;
   int bad;
   int en_cnt;
   int cur_k;

   int qs [0:3];
   int qc [0:3];

   nco_sincos_32x16 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clken     (clken),
      .phi_inc_i (phi_inc_i),
      .fsin_o    (fsin_o),
      .fcos_o    (fcos_o),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "timeout");
   end

   task automatic chk_eq(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int exp);
      total++;
      assert (((obs - exp) <= TOL) && ((exp - obs) <= TOL)) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d+-%0d", tag, obs, exp, TOL);
      end
   endtask

   task automatic chk_sample(input string tag, input int es, input int ec);
      chk_eq({tag, "_valid"}, int'(out_valid), 1);
      chk_near({tag, "_sin"}, int'(fsin_o), es);
      chk_near({tag, "_cos"}, int'(fcos_o), ec);
   endtask

   // one clock; outputs are inspected 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (reset_n && clken) en_cnt++;
      cur_k = en_cnt - LAT;
   endtask

   task automatic adv_to(input int k);
      while (cur_k < k) tick();
   endtask

   task automatic do_reset(input logic [31:0] phi);
      reset_n   = 1'b0;
      clken     = 1'b1;
      phi_inc_i = phi;
      tick();
      chk_eq("rst_valid", int'(out_valid), 0);
      chk_eq("rst_sin", int'(fsin_o), 0);
      chk_eq("rst_cos", int'(fcos_o), 0);
      reset_n = 1'b1;
      en_cnt  = 0;
      cur_k   = -LAT;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      en_cnt = 0;
      cur_k  = -LAT;
      qs[0] = 0;      qc[0] = 32767;
      qs[1] = 32767;  qc[1] = 0;
      qs[2] = 0;      qc[2] = -32767;
      qs[3] = -32767; qc[3] = 0;

      // ---- power-up reset, with clken low on the final reset edge ----
      reset_n   = 1'b0;
      clken     = 1'b1;
      phi_inc_i = PHI1;
      tick();
      tick();
      clken = 1'b0;
      tick();
      chk_eq("por_valid", int'(out_valid), 0);
      chk_eq("por_sin", int'(fsin_o), 0);
      chk_eq("por_cos", int'(fcos_o), 0);
      clken   = 1'b1;
      reset_n = 1'b1;
      en_cnt  = 0;
      cur_k   = -LAT;

      // ---- 10 kHz tone: fill, then quadrant points of the first period ----
      for (int e = 1; e < LAT; e++) begin
         tick();
         chk_eq("fill_valid", int'(out_valid), 0);
         chk_eq("fill_sin", int'(fsin_o), 0);
         chk_eq("fill_cos", int'(fcos_o), 0);
      end
      tick();
      chk_sample("k0", 0, 32767);
      adv_to(300);
      chk_sample("k300", 23170, 23170);
      adv_to(600);
      chk_sample("k600", 32767, 0);
      adv_to(1200);
      chk_sample("k1200", 0, -32767);
      adv_to(1800);
      chk_sample("k1800", -32767, 0);
      adv_to(2400);
      chk_sample("k2400", 0, 32767);

      // ---- one-cycle reset mid-stream, restart, then doubled increment ----
      do_reset(PHI1);
      for (int e = 1; e < LAT; e++) begin
         tick();
         chk_eq("refill_valid", int'(out_valid), 0);
      end
      tick();
      chk_sample("re_k0", 0, 32767);
      // after this point the next enabled edge captures sample 600
      // and is the first to add the new increment
      adv_to(600 - LAT);
      phi_inc_i = PHI2;
      adv_to(600);
      chk_sample("chg_k600", 32767, 0);
      adv_to(750);
      chk_sample("chg_k750", 23170, -23170);
      adv_to(900);
      chk_sample("chg_k900", 0, -32767);
      adv_to(1200);
      chk_sample("chg_k1200", -32767, 0);
      adv_to(1500);
      chk_sample("chg_k1500", 0, 32767);

      // ---- quarter-turn increment with a 5-cycle clken hold ----
      do_reset(32'h40000000);
      adv_to(0);
      for (int k = 0; k < 8; k++) begin
         adv_to(k);
         chk_sample("qtr", qs[k % 4], qc[k % 4]);
      end
      clken = 1'b0;
      for (int h = 0; h < 5; h++) begin
         tick();
         chk_sample("qtr_hold", qs[7 % 4], qc[7 % 4]);
      end
      clken = 1'b1;
      for (int k = 8; k < 16; k++) begin
         adv_to(k);
         chk_sample("qtr_resume", qs[k % 4], qc[k % 4]);
      end

      // ---- half-turn increment, clken gap during pipeline fill ----
      do_reset(32'h80000000);
      for (int e = 1; e <= 10; e++) tick();
      clken = 1'b0;
      for (int h = 0; h < 5; h++) begin
         tick();
         chk_eq("gap_valid", int'(out_valid), 0);
      end
      clken = 1'b1;
      for (int e = 11; e < LAT; e++) begin
         tick();
         chk_eq("gapfill_valid", int'(out_valid), 0);
      end
      tick();
      for (int k = 0; k < 6; k++) begin
         adv_to(k);
         chk_sample("half", 0, (k % 2 == 0) ? 32767 : -32767);
      end

      // ---- zero increment: constant output ----
      do_reset(32'h00000000);
      adv_to(0);
      for (int k = 0; k < 4; k++) begin
         adv_to(k);
         chk_sample("dc", 0, 32767);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
